// File: rtl/mac_layer_pkg.sv
// Shared types and requantise helper for the fully-connected layer blocks.
// Define MAC_SAT_EN to make requantise saturate instead of zeroing.
package mac_layer_pkg;

  localparam int DW_DEF    = 8;
  localparam int ACC_W_DEF = 16;
  localparam int SHIFT_DEF = 6;

  typedef enum logic [2:0] {
    IDLE,
    MAC,
    DRAIN,
    WRITE,
    DONE
  } state_e;

  // acc is passed zero-extended to 32 bits; only acc_w bits are meaningful
  function automatic logic [31:0] requantise(
    input logic [31:0] acc,
    input int unsigned acc_w,
    input int unsigned shift,
    input int unsigned dw
  );
    logic [31:0] acc_m;
    logic [31:0] mask;
    logic [31:0] slice;
`ifdef MAC_SAT_EN
    logic [31:0] sign;
`else
    logic [31:0] top;
`endif
    if (acc_w >= 32) begin
      acc_m = acc;
    end else begin
      acc_m = acc & ((32'd1 << acc_w) - 32'd1);
    end
    mask  = (32'd1 << dw) - 32'd1;
    slice = (acc_m >> shift) & mask;
`ifdef MAC_SAT_EN
    sign = (acc_m >> (acc_w - 1)) & 32'd1;
    if (sign != 32'd0) begin
      return 32'd0;
    end else if ((acc_m >> (shift + dw)) != 32'd0) begin
      return mask;
    end else begin
      return slice;
    end
`else
    top = (acc_m >> (shift + dw - 1)) & 32'd1;
    if (top != 32'd0) begin
      return 32'd0;
    end else begin
      return slice;
    end
`endif
  endfunction

endpackage

// File: rtl/mac_layer_sched_pe.sv
// Shared multiply-accumulate element: product, bias and accumulator registers.
// Output requantise follows MAC_SAT_EN through the package helper.
module mac_pe
  import mac_layer_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mac_vld,
  input  logic          mac_first,
  input  logic [DW-1:0] act_data,
  input  logic [DW-1:0] w_data,
  input  logic [DW-1:0] b_data,
  input  logic          wr_en,
  output logic [DW-1:0] out_data
);

  logic                    v1_q, v1_d;
  logic                    f1_q, f1_d;
  logic                    v2_q, v2_d;
  logic                    f2_q, f2_d;
  logic signed [DW-1:0]    bias_q, bias_d;
  logic signed [ACC_W-1:0] prod_q, prod_d;
  logic [ACC_W-1:0]        acc_q, acc_d;

  logic signed [DW:0]      a_s;
  logic signed [DW-1:0]    w_s;
  logic signed [2*DW:0]    p_full;

  always_comb begin
    a_s    = $signed({1'b0, act_data});
    w_s    = $signed(w_data);
    p_full = a_s * w_s;
    prod_d = ACC_W'(p_full);

    v1_d = mac_vld;
    f1_d = mac_first;
    v2_d = v1_q;
    f2_d = f1_q;

    // bias arrives alongside the first product of a neuron
    bias_d = f1_q ? $signed(b_data) : bias_q;

    acc_d = acc_q;
    if (f2_q) begin
      acc_d = ACC_W'(bias_q) + prod_q;
    end else if (v2_q) begin
      acc_d = acc_q + prod_q;
    end

    out_data = '0;
    if (wr_en) begin
      out_data = DW'(requantise(32'(acc_q), ACC_W, SHIFT, DW));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q   <= 1'b0;
      f1_q   <= 1'b0;
      v2_q   <= 1'b0;
      f2_q   <= 1'b0;
      bias_q <= '0;
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      v1_q   <= v1_d;
      f1_q   <= f1_d;
      v2_q   <= v2_d;
      f2_q   <= f2_d;
      bias_q <= bias_d;
      prod_q <= prod_d;
      acc_q  <= acc_d;
    end
  end

endmodule

// File: rtl/mac_layer_sched.sv
// Time-multiplexed fully-connected layer scheduler over one shared MAC.
// Build option MAC_SAT_EN selects saturating requantisation.
module mac_layer_sched
  import mac_layer_pkg::*;
#(
  parameter int N_IN  = 30,
  parameter int N_OUT = 16,
  parameter int DW    = DW_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int SHIFT = SHIFT_DEF,
  localparam int KW   = $clog2(N_IN),
  localparam int WAW  = $clog2(N_IN * N_OUT),
  localparam int NAW  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic [KW-1:0]  act_addr,
  input  logic [DW-1:0]  act_data,
  output logic [WAW-1:0] w_addr,
  input  logic [DW-1:0]  w_data,
  output logic [NAW-1:0] b_addr,
  input  logic [DW-1:0]  b_data,
  output logic           out_we,
  output logic [NAW-1:0] out_addr,
  output logic [DW-1:0]  out_data
);

  localparam logic [KW-1:0]  K_LAST = KW'(N_IN - 1);
  localparam logic [NAW-1:0] N_LAST = NAW'(N_OUT - 1);

  state_e         state_q, state_d;
  logic [NAW-1:0] n_q, n_d;
  logic           dr_q, dr_d;
  logic [KW-1:0]  act_addr_q, act_addr_d;
  logic [WAW-1:0] w_addr_q, w_addr_d;
  logic [NAW-1:0] b_addr_q, b_addr_d;

  logic mac_vld;
  logic mac_first;

  // act_addr doubles as the k counter within a neuron
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    dr_d       = dr_q;
    act_addr_d = act_addr_q;
    w_addr_d   = w_addr_q;
    b_addr_d   = b_addr_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = MAC;
          n_d        = '0;
          act_addr_d = '0;
          w_addr_d   = '0;
          b_addr_d   = '0;
        end
      end
      MAC: begin
        if (act_addr_q == K_LAST) begin
          state_d = DRAIN;
          dr_d    = 1'b0;
        end else begin
          act_addr_d = act_addr_q + KW'(1);
          w_addr_d   = w_addr_q + WAW'(1);
        end
      end
      DRAIN: begin
        if (dr_q) begin
          state_d = WRITE;
        end else begin
          dr_d = 1'b1;
        end
      end
      WRITE: begin
        if (n_q == N_LAST) begin
          state_d = DONE;
        end else begin
          // weight rows are contiguous, so the next base is one past
          state_d    = MAC;
          n_d        = n_q + NAW'(1);
          act_addr_d = '0;
          w_addr_d   = w_addr_q + WAW'(1);
          b_addr_d   = n_q + NAW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      n_q        <= '0;
      dr_q       <= 1'b0;
      act_addr_q <= '0;
      w_addr_q   <= '0;
      b_addr_q   <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      dr_q       <= dr_d;
      act_addr_q <= act_addr_d;
      w_addr_q   <= w_addr_d;
      b_addr_q   <= b_addr_d;
    end
  end

  always_comb begin
    busy      = (state_q == MAC) || (state_q == DRAIN) ||
                (state_q == WRITE);
    done      = (state_q == DONE);
    out_we    = (state_q == WRITE);
    out_addr  = n_q;
    act_addr  = act_addr_q;
    w_addr    = w_addr_q;
    b_addr    = b_addr_q;
    mac_vld   = (state_q == MAC);
    mac_first = mac_vld && (act_addr_q == '0);
  end

  mac_pe #(
    .DW    (DW),
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_pe (
    .clk       (clk),
    .reset     (reset),
    .mac_vld   (mac_vld),
    .mac_first (mac_first),
    .act_data  (act_data),
    .w_data    (w_data),
    .b_data    (b_data),
    .wr_en     (out_we),
    .out_data  (out_data)
  );

endmodule

// File: tb/tb_mac_layer_sched.sv
// Bench for mac_layer_sched: directed table, random passes, abort and start-spam.
// Expected outputs follow MAC_SAT_EN when the bench is built with it.
module tb_mac_layer_sched;

  localparam int N_IN  = 30;
  localparam int N_OUT = 16;
  localparam int DW    = 8;
  localparam int LAT   = N_OUT * (N_IN + 3) + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy;
  logic       done;
  logic [4:0] act_addr;
  logic [7:0] act_data;
  logic [8:0] w_addr;
  logic [7:0] w_data;
  logic [3:0] b_addr;
  logic [7:0] b_data;
  logic       out_we;
  logic [3:0] out_addr;
  logic [7:0] out_data;

  logic [7:0] act_mem [N_IN];
  logic [7:0] w_mem   [N_IN*N_OUT];
  logic [7:0] b_mem   [N_OUT];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int wr_addr [$];
  int wr_data [$];

  typedef struct {
    logic [7:0] act;
    logic [7:0] w;
    int         bidx;
    logic [7:0] bval;
    logic [7:0] exp3;
    logic [7:0] exp_o;
  } vec_t;

  vec_t vecs [4];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    act_data <= act_mem[act_addr];
    w_data   <= w_mem[w_addr];
    b_data   <= b_mem[b_addr];
  end

  mac_layer_sched #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT),
    .DW    (DW),
    .ACC_W (16),
    .SHIFT (6)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .act_addr (act_addr),
    .act_data (act_data),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .out_we   (out_we),
    .out_addr (out_addr),
    .out_data (out_data)
  );

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (out_we === 1'b1) begin
      wr_addr.push_back(int'(out_addr));
      wr_data.push_back(int'(out_data));
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: signed dot product plus bias, wrapped to 16 bits, then requantised
  function automatic int ref_out(int n);
    int acc;
    int a16;
    acc = int'($signed(b_mem[n]));
    for (int k = 0; k < N_IN; k++) begin
      acc += int'(act_mem[k]) * int'($signed(w_mem[n*N_IN+k]));
    end
    a16 = acc & 32'hFFFF;
`ifdef MAC_SAT_EN
    if (a16 >= 32768) return 0;
    if (a16 >= 16384) return 255;
    return (a16 >> 6) & 255;
`else
    if (((a16 >> 13) & 1) != 0) return 0;
    return (a16 >> 6) & 255;
`endif
  endfunction

  task automatic fill(input logic [7:0] a, input logic [7:0] w,
                      input int bidx, input logic [7:0] bval);
    for (int i = 0; i < N_IN; i++) act_mem[i] = a;
    for (int i = 0; i < N_IN*N_OUT; i++) w_mem[i] = w;
    for (int i = 0; i < N_OUT; i++) b_mem[i] = 8'h00;
    if (bidx >= 0) b_mem[bidx] = bval;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0;
  endtask

  task automatic check_writes(input string tag);
    check($sformatf("%s writes", tag), wr_addr.size(), N_OUT);
    for (int i = 0; i < N_OUT && i < wr_addr.size(); i++) begin
      check($sformatf("%s addr[%0d]", tag, i), wr_addr[i], i);
      check($sformatf("%s data[%0d]", tag, i), wr_data[i], ref_out(i));
    end
  endtask

  task automatic run_pass(input string tag);
    int c0;
    clear_log();
    start = 1'b1;
    c0 = cyc;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2000 && done_cnt == 0; i++) tick();
    check($sformatf("%s done", tag), done_cnt, 1);
    check($sformatf("%s latency", tag), done_cyc - c0, LAT);
    tick();
    check($sformatf("%s idle busy", tag), busy, 0);
    check_writes(tag);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    fill(8'd0, 8'd0, -1, 8'd0);
    repeat (3) tick();
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst out_we", out_we, 0);
    check("rst out_addr", out_addr, 0);
    check("rst out_data", out_data, 0);
    check("rst act_addr", act_addr, 0);
    check("rst w_addr", w_addr, 0);
    check("rst b_addr", b_addr, 0);
    reset = 1'b0;
    tick();

    vecs[0] = '{8'd64, 8'd1, -1, 8'd0, 8'd30, 8'd30};
    vecs[1] = '{8'd64, 8'd1, 3, 8'd64, 8'd31, 8'd30};
    vecs[2] = '{8'd64, 8'hFF, -1, 8'd0, 8'd0, 8'd0};
`ifdef MAC_SAT_EN
    vecs[3] = '{8'd255, 8'd127, -1, 8'd0, 8'd0, 8'd0};
`else
    vecs[3] = '{8'd255, 8'd127, -1, 8'd0, 8'd76, 8'd76};
`endif

    for (int v = 0; v < 4; v++) begin
      fill(vecs[v].act, vecs[v].w, vecs[v].bidx, vecs[v].bval);
      run_pass($sformatf("vec%0d", v));
      if (wr_data.size() == N_OUT) begin
        for (int i = 0; i < N_OUT; i++) begin
          check($sformatf("vec%0d table[%0d]", v, i), wr_data[i],
                (i == 3) ? vecs[v].exp3 : vecs[v].exp_o);
        end
      end
    end

    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < N_IN; i++) act_mem[i] = 8'($urandom);
      for (int i = 0; i < N_IN*N_OUT; i++) w_mem[i] = 8'($urandom);
      for (int i = 0; i < N_OUT; i++) b_mem[i] = 8'($urandom);
      run_pass($sformatf("rand%0d", r));
    end

    // abort during neuron 5's MAC phase
    fill(8'd64, 8'd1, -1, 8'd0);
    clear_log();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 1000 && wr_addr.size() < 5; i++) tick();
    check("abort reached n5", wr_addr.size(), 5);
    repeat (10) tick();
    check("abort busy before", busy, 1);
    reset = 1'b1;
    tick();
    check("abort busy after", busy, 0);
    check("abort out_we", out_we, 0);
    reset = 1'b0;
    begin
      int nw;
      nw = wr_addr.size();
      repeat (700) tick();
      check("abort no writes", wr_addr.size(), nw);
      check("abort no done", done_cnt, 0);
    end
    run_pass("post-abort");

    // start held high through a whole pass, including the done cycle
    clear_log();
    begin
      int c0;
      start = 1'b1;
      c0 = cyc;
      tick();
      for (int i = 0; i < 2000 && done_cnt == 0; i++) tick();
      check("spam latency", done_cyc - c0, LAT);
      tick();
      start = 1'b0;
      check("spam idle busy", busy, 0);
      tick();
      check("spam no restart", busy, 0);
      check("spam done count", done_cnt, 1);
      check_writes("spam");
    end
    run_pass("after-spam");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
